l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Shares the single L2 cache port between `NUM_REQ` L1 caches, for example an instruction L1 and a data L1. Each L1 signals a request with a one-cycle `read`/`write` pulse, then waits for `ready`. The arbiter latches each pulse into a per-requester pending slot, serves the slots round-robin one at a time over the L2 interface, and returns the L2 block and hit status to the granted requester only.

## Interface
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 32: address width.
- `BLOCK_SIZE`, 16: words per cache block.
- `NUM_REQ`, 2: number of L1 requesters, 2..8.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_addr` in `[NUM_REQ][ADDR_WIDTH]`: per-requester address, sampled on the request pulse.
- `req_wdata` in `[NUM_REQ][BLOCK_SIZE][DATA_WIDTH]`: per-requester write block, sampled on the request pulse.
- `req_read` in `[NUM_REQ]`: read request pulse.
- `req_write` in `[NUM_REQ]`: write request pulse.
- `req_rdata` out `[BLOCK_SIZE][DATA_WIDTH]`: returned block; valid only with a `req_ready` bit.
- `req_ready` out `[NUM_REQ]`: one-cycle completion pulse, at most one bit set.
- `req_hit` out `[NUM_REQ]`: L2 hit status, qualified by `req_ready`.
- `l2_addr` out `ADDR_WIDTH`: L2 address.
- `l2_data_out` out `[BLOCK_SIZE][DATA_WIDTH]`: block written to L2.
- `l2_data_in` in `[BLOCK_SIZE][DATA_WIDTH]`: block read from L2.
- `l2_read` out 1: L2 read pulse.
- `l2_write` out 1: L2 write pulse.
- `l2_ready` in 1: L2 completion.
- `l2_hit` in 1: L2 hit status.
- `grant` out `$clog2(NUM_REQ)`: requester currently owning L2 (debug).
- `busy` out 1: state is not IDLE.

## Operation
**Capture**
- Each requester has a pending slot holding addr, wdata, kind and a valid bit.
- A pulse on `req_read[i]` or `req_write[i]` with slot i empty loads the slot.
- If both read and write are high in the same cycle, the request is a write.
- A pulse while slot i is already valid is dropped. This is a protocol violation.

**FSM states: IDLE, ISSUE, WAIT**
- IDLE: if any slot is valid, the round-robin picker selects g, searching from `rr_ptr` upward with wrap. The arbiter sets `grant`=g, registers `l2_addr`, `l2_data_out` and kind, and goes to ISSUE.
- ISSUE: `l2_read` or `l2_write` is high for exactly this cycle. Next state is WAIT.
- WAIT: `l2_read`/`l2_write` are 0 and `l2_addr`/`l2_data_out` are held. When `l2_ready`=1:
  - register `req_rdata`=`l2_data_in`, `req_ready[g]`=1, `req_hit[g]`=`l2_hit`;
  - clear slot g;
  - set `rr_ptr`=(g+1) mod `NUM_REQ`;
  - go to IDLE.
- `l2_ready` is ignored outside WAIT.
- The response is also returned for writes; the requester ignores `req_rdata`.

**Boundary conditions**
- If slot g clears and requester g pulses again in the same cycle, set wins: the new request is captured.
- If all slots are valid, the arbiter services them in strict rotation, so no requester waits more than `NUM_REQ`-1 transactions.

**Reset**
- Clears all slots and sets `rr_ptr`=0 and state=IDLE.
- Output reset values: `l2_read`=`l2_write`=0, `l2_addr`=0, `l2_data_out`=0, `req_ready`=0, `req_hit`=0, `req_rdata`=0, `grant`=0, `busy`=0.
- Reset mid-transaction abandons the transaction; a late `l2_ready` is ignored.

## Timing
- All outputs are registered.
- Request pulse sampled at edge t → `l2_read`/`l2_write` high during the cycle after edge t+1, for exactly one cycle.
- `l2_ready` sampled at edge u while in WAIT → `req_ready[g]` high during the cycle after edge u, for one cycle.
- Minimum request-to-ready time: 4 edges when L2 answers on its first WAIT cycle.
- Back-to-back transactions: at least one IDLE cycle between completion and the next ISSUE.

## Structure
- Package `l2_arb_pkg` holds the state enum (IDLE/ISSUE/WAIT), the `block_t` packed typedef `[BLOCK_SIZE][DATA_WIDTH]`, and the request-kind enum (RD/WR).
- Sub-module `rr_picker`: combinational. Inputs are the valid vector and `rr_ptr`; outputs are an any-valid flag and the selected index. It is instantiated once.

## Test plan
- Single read: requester 0 pulses read to addr 0x100; L2 returns block word0=0xA5A5 with `l2_hit`=1 after 3 cycles → one `l2_read` pulse with `l2_addr`=0x100, then `req_ready`=01, `req_hit[0]`=1, `req_rdata[0]`=0xA5A5.
- Simultaneous requests: requesters 0 and 1 both pulse read in the same cycle, with `rr_ptr`=0 → requester 0 is served first, then 1; exactly two `l2_read` pulses; `req_ready` goes 01 then 10.
- Fairness: requester 0 re-requests immediately after each completion while requester 1 is pending → the grants alternate 0,1,0,1 over 4 transactions.
- Write: requester 1 pulses write to 0x200 with a block whose words are all 0x5 → `l2_write` pulse with `l2_addr`=0x200 and `l2_data_out` equal to that block; `req_ready[1]` follows `l2_ready`.
- Protocol edges:
  - a duplicate pulse while pending is dropped, giving only one L2 transaction;
  - `l2_ready` asserted while in IDLE causes no `req_ready`.
- Reset mid-WAIT: assert `rst_n`=0 during WAIT, then raise `l2_ready` after reset is released → all outputs are 0, and no `req_ready` ever follows.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter.
package l2_arb_pkg;

    localparam int L2_DATA_WIDTH = 32;
    localparam int L2_ADDR_WIDTH = 32;
    localparam int L2_BLOCK_SIZE = 16;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Plain constants mirroring the enum, for the legacy-style state register.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;

    // One cache block at the default geometry.
    typedef logic [L2_BLOCK_SIZE-1:0][L2_DATA_WIDTH-1:0] block_t;

    // Kind of a pending request.
    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } req_kind_e;

endpackage

// File: rtl/l2_arbiter_rr_picker.sv
// Round-robin picker: first valid slot at or after i_ptr, wrapping.
module rr_picker
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_vld,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic                       o_any,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int GW = $clog2(NUM_REQ);

    int          w_pos;
    logic [GW-1:0] w_idx;

    // Scan from the farthest candidate down so the one closest to i_ptr wins.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_pos = 0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_idx = GW'(w_pos);
            if (i_vld[w_idx]) begin
                o_any = 1'b1;
                o_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 port between NUM_REQ L1 caches: per-requester pending slots,
// round-robin service, one transaction in flight at a time.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int DATA_WIDTH = L2_DATA_WIDTH,
    parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int BLOCK_SIZE = L2_BLOCK_SIZE,
    parameter int NUM_REQ    = 2
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]               i_req_addr,
    input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] i_req_wdata,
    input  logic [NUM_REQ-1:0]                               i_req_read,
    input  logic [NUM_REQ-1:0]                               i_req_write,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]            o_req_rdata,
    output logic [NUM_REQ-1:0]                               o_req_ready,
    output logic [NUM_REQ-1:0]                               o_req_hit,
    output logic [ADDR_WIDTH-1:0]                            o_l2_addr,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]            o_l2_data_out,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]            i_l2_data_in,
    output logic                                             o_l2_read,
    output logic                                             o_l2_write,
    input  logic                                             i_l2_ready,
    input  logic                                             i_l2_hit,
    output logic [$clog2(NUM_REQ)-1:0]                       o_grant,
    output logic                                             o_busy
);

    localparam int GW = $clog2(NUM_REQ);

    // Pending slots
    logic [NUM_REQ-1:0]                                r_slot_vld;
    logic [NUM_REQ-1:0]                                r_slot_kind;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                r_slot_addr;
    logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_slot_wdata;

    // Control
    logic [1:0]    r_state;
    logic [GW-1:0] r_rr_ptr;
    logic [GW-1:0] r_grant;

    // L2 side
    logic                                  r_l2_read;
    logic                                  r_l2_write;
    logic [ADDR_WIDTH-1:0]                 r_l2_addr;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_l2_data_out;

    // Requester side
    logic [NUM_REQ-1:0]                    r_req_ready;
    logic [NUM_REQ-1:0]                    r_req_hit;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_req_rdata;

    logic               w_done;
    logic               w_any;
    logic [GW-1:0]      w_pick;
    logic [NUM_REQ-1:0] w_clr;
    logic [NUM_REQ-1:0] w_load;

    // L2 completion only counts while a transaction is waiting for it.
    assign w_done = (r_state == ST_WAIT) && i_l2_ready;

    // Slot clear on completion, slot load on a pulse; a clearing slot is free
    // again this same cycle, so a simultaneous new pulse is captured.
    always_comb begin
        w_clr  = '0;
        w_load = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_clr[i]  = w_done && (r_grant == GW'(i));
            w_load[i] = (i_req_read[i] || i_req_write[i]) &&
                        (!r_slot_vld[i] || w_clr[i]);
        end
    end

    // Slot valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_vld <= '0;
        end else begin
            r_slot_vld <= (r_slot_vld & ~w_clr) | w_load;
        end
    end

    // Slot payload; a write pulse wins over a simultaneous read pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_load[i]) begin
                r_slot_addr[i]  <= i_req_addr[i];
                r_slot_wdata[i] <= i_req_wdata[i];
                r_slot_kind[i]  <= i_req_write[i] ? WR : RD;
            end
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_vld (r_slot_vld),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    // Arbiter FSM: pick in IDLE, pulse L2 in ISSUE, hold the request in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_l2_read     <= 1'b0;
            r_l2_write    <= 1'b0;
            r_l2_addr     <= '0;
            r_l2_data_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant       <= w_pick;
                        r_l2_addr     <= r_slot_addr[w_pick];
                        r_l2_data_out <= r_slot_wdata[w_pick];
                        r_l2_read     <= (r_slot_kind[w_pick] == RD);
                        r_l2_write    <= (r_slot_kind[w_pick] == WR);
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_l2_read  <= 1'b0;
                    r_l2_write <= 1'b0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_l2_ready) begin
                        r_rr_ptr <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion response back to the granted requester, one cycle wide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_ready <= '0;
            r_req_hit   <= '0;
            r_req_rdata <= '0;
        end else begin
            r_req_ready <= '0;
            r_req_hit   <= '0;
            if (w_done) begin
                r_req_ready[r_grant] <= 1'b1;
                r_req_hit[r_grant]   <= i_l2_hit;
                r_req_rdata          <= i_l2_data_in;
            end
        end
    end

    assign o_req_rdata   = r_req_rdata;
    assign o_req_ready   = r_req_ready;
    assign o_req_hit     = r_req_hit;
    assign o_l2_addr     = r_l2_addr;
    assign o_l2_data_out = r_l2_data_out;
    assign o_l2_read     = r_l2_read;
    assign o_l2_write    = r_l2_write;
    assign o_grant       = r_grant;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: vector table for single transactions plus
// hand-written sequences for arbitration, protocol edges and reset.
module tb_l2_arbiter;
    import l2_arb_pkg::*;

    localparam int NR = 2;
    localparam int BS = L2_BLOCK_SIZE;
    localparam int DW = L2_DATA_WIDTH;
    localparam int AW = L2_ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0][AW-1:0]         req_addr;
    logic [NR-1:0][BS-1:0][DW-1:0] req_wdata;
    logic [NR-1:0]                 req_read;
    logic [NR-1:0]                 req_write;
    block_t                        req_rdata;
    logic [NR-1:0]                 req_ready;
    logic [NR-1:0]                 req_hit;
    logic [AW-1:0]                 l2_addr;
    block_t                        l2_data_out;
    block_t                        l2_data_in;
    logic                          l2_read;
    logic                          l2_write;
    logic                          l2_ready;
    logic                          l2_hit;
    logic [0:0]                    grant;
    logic                          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BLOCK_SIZE (BS),
        .NUM_REQ    (NR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_read    (req_read),
        .i_req_write   (req_write),
        .o_req_rdata   (req_rdata),
        .o_req_ready   (req_ready),
        .o_req_hit     (req_hit),
        .o_l2_addr     (l2_addr),
        .o_l2_data_out (l2_data_out),
        .i_l2_data_in  (l2_data_in),
        .o_l2_read     (l2_read),
        .o_l2_write    (l2_write),
        .i_l2_ready    (l2_ready),
        .i_l2_hit      (l2_hit),
        .o_grant       (grant),
        .o_busy        (busy)
    );

    typedef struct {
        int          req;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wword;
        int          dly;
        bit          hit;
        logic [31:0] rword;
        bit          exp_wr;
    } vec_t;

    vec_t vecs[4];

    function automatic block_t fill(input logic [31:0] base, input bit inc);
        block_t b;
        for (int j = 0; j < BS; j++) begin
            b[j] = inc ? base + 32'(j) : base;
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_req();
        req_read  = '0;
        req_write = '0;
    endtask

    task automatic set_req(input int idx, input bit rd, input bit wr,
                           input logic [31:0] addr, input block_t wd);
        req_addr[idx]  = addr;
        req_wdata[idx] = wd;
        req_read[idx]  = rd;
        req_write[idx] = wr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_req();
        l2_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Waits for the L2 command pulse; n is how many negedges it took.
    task automatic wait_issue(output int n);
        bit got;
        got = 1'b0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            clr_req();
            if (l2_read || l2_write) begin
                n = c;
                got = 1'b1;
                break;
            end
        end
        check("issue_seen", 64'(got), 64'd1);
    endtask

    // Called on the ISSUE-cycle negedge; answers after dly WAIT cycles.
    task automatic respond(input int dly, input bit hit, input logic [31:0] rword, input int rp);
        for (int c = 0; c < dly; c++) begin
            @(negedge clk);
            clr_req();
            if (c == 0) begin
                check("l2_pulse_one_cycle", {62'd0, l2_read, l2_write}, 64'd0);
            end
            check("no_early_ready", 64'(req_ready), 64'd0);
        end
        l2_ready   = 1'b1;
        l2_hit     = hit;
        l2_data_in = fill(rword, 1'b1);
        if (rp >= 0) begin
            req_read[rp] = 1'b1;
        end
        @(negedge clk);
        l2_ready = 1'b0;
        l2_hit   = 1'b0;
        clr_req();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_l2_read"},  64'(l2_read), 64'd0);
        check({tag, "_l2_write"}, 64'(l2_write), 64'd0);
        check({tag, "_l2_addr"},  64'(l2_addr), 64'd0);
        check({tag, "_l2_dout"},  64'(l2_data_out == '0), 64'd1);
        check({tag, "_ready"},    64'(req_ready), 64'd0);
        check({tag, "_hit"},      64'(req_hit), 64'd0);
        check({tag, "_rdata"},    64'(req_rdata == '0), 64'd1);
        check({tag, "_grant"},    64'(grant), 64'd0);
        check({tag, "_busy"},     64'(busy), 64'd0);
    endtask

    task automatic count_strays(input int cycles, output int strays);
        strays = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (l2_read || l2_write || (req_ready != '0)) begin
                strays++;
            end
        end
    endtask

    initial begin
        int n;
        int strays;
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_hit;

        rst_n      = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_read   = '0;
        req_write  = '0;
        l2_data_in = '0;
        l2_ready   = 1'b0;
        l2_hit     = 1'b0;

        //            req rd    wr    addr        wword      dly hit   rword      exp_wr
        vecs[0] = '{0,   1'b1, 1'b0, 32'h100, 32'h0,     3, 1'b1, 32'hA5A5, 1'b0};
        vecs[1] = '{1,   1'b0, 1'b1, 32'h200, 32'h5,     1, 1'b0, 32'h0F00, 1'b1};
        vecs[2] = '{1,   1'b1, 1'b1, 32'h300, 32'h77,    2, 1'b1, 32'h3300, 1'b1};
        vecs[3] = '{0,   1'b1, 1'b0, 32'h400, 32'h1234,  1, 1'b0, 32'h1234, 1'b0};

        // Reset values
        do_reset();
        check_zero("rst");
        rst_n = 1'b1;

        // Single transactions from the vector table
        for (int v = 0; v < 4; v++) begin
            set_req(vecs[v].req, vecs[v].rd, vecs[v].wr, vecs[v].addr, fill(vecs[v].wword, 1'b0));
            wait_issue(n);
            check("issue_latency", 64'(n), 64'd2);
            check("l2_read",  64'(l2_read),  64'(!vecs[v].exp_wr));
            check("l2_write", 64'(l2_write), 64'(vecs[v].exp_wr));
            check("l2_addr",  64'(l2_addr),  64'(vecs[v].addr));
            check("l2_dout",  64'(l2_data_out == fill(vecs[v].wword, 1'b0)), 64'd1);
            check("grant",    64'(grant), 64'(vecs[v].req));
            check("busy",     64'(busy), 64'd1);
            respond(vecs[v].dly, vecs[v].hit, vecs[v].rword, -1);
            exp_rdy = '0;
            exp_rdy[vecs[v].req] = 1'b1;
            exp_hit = '0;
            exp_hit[vecs[v].req] = vecs[v].hit;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("req_hit",   64'(req_hit), 64'(exp_hit));
            check("rdata_w0",  64'(req_rdata[0]), 64'(vecs[v].rword));
            check("rdata_wN",  64'(req_rdata[BS-1]), 64'(vecs[v].rword + 32'(BS - 1)));
            check("addr_held", 64'(l2_addr), 64'(vecs[v].addr));
            @(negedge clk);
            check("ready_one_cycle", 64'(req_ready), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end

        // Simultaneous requests: 0 first, then 1, one IDLE cycle between
        do_reset();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h10, fill(32'h11, 1'b0));
        set_req(1, 1'b1, 1'b0, 32'h20, fill(32'h22, 1'b0));
        wait_issue(n);
        check("sim_first_addr",  64'(l2_addr), 64'h10);
        check("sim_first_grant", 64'(grant), 64'd0);
        respond(1, 1'b1, 32'hB000, -1);
        check("sim_ready0", 64'(req_ready), 64'b01);
        wait_issue(n);
        check("b2b_gap", 64'(n), 64'd1);
        check("sim_second_addr",  64'(l2_addr), 64'h20);
        check("sim_second_grant", 64'(grant), 64'd1);
        check("sim_second_read",  64'(l2_read), 64'd1);
        respond(2, 1'b0, 32'hC000, -1);
        check("sim_ready1", 64'(req_ready), 64'b10);
        check("sim_hit1",   64'(req_hit), 64'b00);
        count_strays(6, strays);
        check("sim_no_extra", 64'(strays), 64'd0);

        // Fairness with re-requests landing on the clearing cycle
        do_reset();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h30, fill(32'h0, 1'b0));
        set_req(1, 1'b1, 1'b0, 32'h40, fill(32'h0, 1'b0));
        for (int t = 0; t < 4; t++) begin
            wait_issue(n);
            check("fair_grant", 64'(grant), 64'(t % 2));
            check("fair_addr",  64'(l2_addr), (t % 2 == 0) ? 64'h30 : 64'h40);
            respond(1, 1'b0, 32'(t), (t < 2) ? (t % 2) : -1);
            exp_rdy = '0;
            exp_rdy[t % 2] = 1'b1;
            check("fair_ready", 64'(req_ready), 64'(exp_rdy));
        end
        count_strays(6, strays);
        check("fair_no_extra", 64'(strays), 64'd0);

        // Duplicate pulse while pending is dropped
        do_reset();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h500, fill(32'h0, 1'b0));
        wait_issue(n);
        req_read[0] = 1'b1;
        respond(1, 1'b1, 32'h5000, -1);
        check("dup_ready", 64'(req_ready), 64'b01);
        count_strays(8, strays);
        check("dup_dropped", 64'(strays), 64'd0);

        // l2_ready while IDLE is ignored
        l2_ready = 1'b1;
        count_strays(4, strays);
        l2_ready = 1'b0;
        check("idle_l2_ready_ignored", 64'(strays), 64'd0);
        check("idle_busy_after", 64'(busy), 64'd0);

        // Reset in WAIT abandons the transaction
        set_req(1, 1'b1, 1'b0, 32'h600, fill(32'h66, 1'b0));
        wait_issue(n);
        check("rstw_issue_addr", 64'(l2_addr), 64'h600);
        @(negedge clk);
        check("rstw_in_wait", 64'(busy), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("rstw_during");
        rst_n      = 1'b1;
        l2_ready   = 1'b1;
        l2_hit     = 1'b1;
        l2_data_in = fill(32'hDEAD, 1'b1);
        @(negedge clk);
        check_zero("rstw_after");
        count_strays(3, strays);
        l2_ready = 1'b0;
        l2_hit   = 1'b0;
        check("rstw_late_ready", 64'(strays), 64'd0);
        count_strays(6, strays);
        check("rstw_no_reissue", 64'(strays), 64'd0);
        check_zero("rstw_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
